// File: rtl/execute_pipe.sv
// rtl/execute_pipe.sv - Y86-64 execute stage with CC register and one-slot output buffer
//
// Purpose: computes valE and Cnd from icode/ifun/valA/valB/valC, owns the
// condition codes {ZF,SF,OF} and registers each result into a single output
// slot with valid/ready handshakes on both sides.
// Optional feature macro: EXE_MUL_EN (adds iterative OPq ifun 4 = mulq).
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   in_valid_i / in_ready_o      upstream handshake (decode)
//   icode_i, ifun_i              instruction code / function
//   valA_i, valB_i, valC_i       operands
//   set_cc_i                     allow OPq to write the condition codes
//   out_valid_o / out_ready_i    downstream handshake (memory)
//   icode_o, valA_o, valE_o      registered results
//   Cnd_o, instr_err_o           registered condition / illegal flags
//   cc_o                         live condition codes {ZF,SF,OF}
//   busy_o                       multi-cycle operation in progress
module execute_pipe #(
    parameter int DATA_W     = 64,
    parameter int STACK_STEP = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        icode_i,
    input  logic [3:0]        ifun_i,
    input  logic [DATA_W-1:0] valA_i,
    input  logic [DATA_W-1:0] valB_i,
    input  logic [DATA_W-1:0] valC_i,
    input  logic              set_cc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [3:0]        icode_o,
    output logic [DATA_W-1:0] valA_o,
    output logic [DATA_W-1:0] valE_o,
    output logic              Cnd_o,
    output logic [2:0]        cc_o,
    output logic              instr_err_o,
    output logic              busy_o
);
    localparam int MSB = DATA_W - 1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    logic              out_valid_q;
    logic [3:0]        icode_q;
    logic [DATA_W-1:0] valA_q;
    logic [DATA_W-1:0] valE_q;
    logic              cnd_q;
    logic              err_q;
    logic [2:0]        cc_q;

    logic [DATA_W-1:0] valE_d;
    logic              cnd_d;
    logic              err_d;
    logic              of_d;
    logic              is_mul_d;
    logic              cc_we_d;
    logic [2:0]        cc_d;

    logic accept;
    logic pop;
    logic busy;

`ifdef EXE_MUL_EN
    localparam int CNT_W = $clog2(DATA_W);
    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t            state_q;
    logic [CNT_W-1:0]  mul_cnt_q;
    logic [DATA_W-1:0] mul_acc_q;
    logic [DATA_W-1:0] mul_a_q;     // multiplicand, shifts left each step
    logic [DATA_W-1:0] mul_b_q;     // multiplier, shifts right each step
    logic              mul_setcc_q;
    logic [DATA_W-1:0] mul_sum;

    assign mul_sum = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);
    assign busy    = (state_q == S_MUL);
`else
    assign busy    = 1'b0;
`endif

    // Condition evaluation against the flags as they stand before this instruction.
    function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
        logic zf, lt;
        zf = cc[2];
        lt = cc[1] ^ cc[0];
        case (fn)
            4'h0:    cond_eval = 1'b1;
            4'h1:    cond_eval = lt | zf;
            4'h2:    cond_eval = lt;
            4'h3:    cond_eval = zf;
            4'h4:    cond_eval = ~zf;
            4'h5:    cond_eval = ~lt;
            4'h6:    cond_eval = ~lt & ~zf;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    always_comb begin
        valE_d   = '0;
        cnd_d    = 1'b0;
        err_d    = 1'b0;
        of_d     = 1'b0;
        is_mul_d = 1'b0;
        case (icode_i)
            4'h0, 4'h1: begin
            end
            I_CMOV: begin
                valE_d = valA_i;
                cnd_d  = cond_eval(ifun_i, cc_q);
                err_d  = (ifun_i > 4'h6);
            end
            I_IRMOV:         valE_d = valC_i;
            I_RMMOV, I_MRMOV: valE_d = valB_i + valC_i;
            I_OP: begin
                case (ifun_i)
                    4'h0: begin
                        valE_d = valB_i + valA_i;
                        of_d   = (valA_i[MSB] == valB_i[MSB]) && (valE_d[MSB] != valA_i[MSB]);
                    end
                    4'h1: begin
                        valE_d = valB_i - valA_i;
                        of_d   = (valB_i[MSB] != valA_i[MSB]) && (valE_d[MSB] != valB_i[MSB]);
                    end
                    4'h2: valE_d = valB_i & valA_i;
                    4'h3: valE_d = valB_i ^ valA_i;
`ifdef EXE_MUL_EN
                    4'h4: is_mul_d = 1'b1;
`endif
                    default: err_d = 1'b1;
                endcase
            end
            I_JXX: begin
                cnd_d = cond_eval(ifun_i, cc_q);
                err_d = (ifun_i > 4'h6);
            end
            I_CALL, I_PUSH: valE_d = valB_i - DATA_W'(STACK_STEP);
            I_RET, I_POP:   valE_d = valB_i + DATA_W'(STACK_STEP);
            default: err_d = 1'b1;
        endcase
        if (err_d) begin
            valE_d = '0;
            cnd_d  = 1'b0;
        end
        cc_we_d = (icode_i == I_OP) && !err_d && !is_mul_d && set_cc_i;
        cc_d    = {valE_d == '0, valE_d[MSB], of_d};
    end

    assign pop    = out_valid_q & out_ready_i;
    assign accept = in_valid_i & in_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            icode_q     <= '0;
            valA_q      <= '0;
            valE_q      <= '0;
            cnd_q       <= 1'b0;
            err_q       <= 1'b0;
            cc_q        <= 3'b100;
`ifdef EXE_MUL_EN
            state_q     <= S_IDLE;
            mul_cnt_q   <= '0;
            mul_acc_q   <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_setcc_q <= 1'b0;
`endif
        end else begin
            if (pop) out_valid_q <= 1'b0;
            if (accept) begin
                // Slot is empty (or being popped) whenever accept is high,
                // so loading icode/valA early for a mul is invisible downstream.
                icode_q <= icode_i;
                valA_q  <= valA_i;
                if (!is_mul_d) begin
                    out_valid_q <= 1'b1;
                    valE_q      <= valE_d;
                    cnd_q       <= cnd_d;
                    err_q       <= err_d;
                    if (cc_we_d) cc_q <= cc_d;
                end
`ifdef EXE_MUL_EN
                else begin
                    state_q     <= S_MUL;
                    mul_cnt_q   <= '0;
                    mul_acc_q   <= '0;
                    mul_a_q     <= valB_i;
                    mul_b_q     <= valA_i;
                    mul_setcc_q <= set_cc_i;
                end
`endif
            end
`ifdef EXE_MUL_EN
            if (state_q == S_MUL) begin
                mul_acc_q <= mul_sum;
                mul_a_q   <= mul_a_q << 1;
                mul_b_q   <= mul_b_q >> 1;
                mul_cnt_q <= mul_cnt_q + CNT_W'(1);
                if (mul_cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b1;
                    valE_q      <= mul_sum;
                    cnd_q       <= 1'b0;
                    err_q       <= 1'b0;
                    if (mul_setcc_q) cc_q <= {mul_sum == '0, mul_sum[MSB], 1'b0};
                end
            end
`endif
        end
    end

    assign in_ready_o  = ~busy & (~out_valid_q | out_ready_i);
    assign out_valid_o = out_valid_q;
    assign icode_o     = icode_q;
    assign valA_o      = valA_q;
    assign valE_o      = valE_q;
    assign Cnd_o       = cnd_q;
    assign cc_o        = cc_q;
    assign instr_err_o = err_q;
    assign busy_o      = busy;
endmodule

// File: tb/tb_execute_pipe.sv
// tb/tb_execute_pipe.sv - scoreboard bench for execute_pipe
module tb_execute_pipe;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [3:0]  icode_i = '0;
    logic [3:0]  ifun_i = '0;
    logic [63:0] valA_i = '0;
    logic [63:0] valB_i = '0;
    logic [63:0] valC_i = '0;
    logic        set_cc_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [3:0]  icode_o;
    logic [63:0] valA_o;
    logic [63:0] valE_o;
    logic        Cnd_o;
    logic [2:0]  cc_o;
    logic        instr_err_o;
    logic        busy_o;

    execute_pipe #(.DATA_W(64), .STACK_STEP(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .icode_i(icode_i), .ifun_i(ifun_i),
        .valA_i(valA_i), .valB_i(valB_i), .valC_i(valC_i),
        .set_cc_i(set_cc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .icode_o(icode_o), .valA_o(valA_o), .valE_o(valE_o),
        .Cnd_o(Cnd_o), .cc_o(cc_o), .instr_err_o(instr_err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] valA;
        logic [63:0] valE;
        logic        cnd;
        logic        err;
    } exp_t;

    exp_t       sb_q[$];
    logic [2:0] m_cc = 3'b100;   // model flags {ZF,SF,OF}
    int         n_checks = 0;
    int         n_fail = 0;
    int         ready_mode = 0;  // 0: always ready, 1: random, 2: hold off
    bit         in_reset = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: architectural effect of one accepted instruction.
    task automatic model_exec(input logic [3:0] ic, input logic [3:0] fn,
                              input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] c, input logic sc);
        exp_t        e;
        logic [64:0] w;
        logic [63:0] r;
        logic        of, lt, zf;
        zf = m_cc[2];
        lt = m_cc[1] ^ m_cc[0];
        e.icode = ic; e.valA = a; e.valE = '0; e.cnd = 1'b0; e.err = 1'b0;
        r = '0; of = 1'b0; w = '0;
        if (ic > 4'hB) begin
            e.err = 1'b1;
        end else if (ic == 4'h6) begin
            case (fn)
                4'h0: begin r = b + a; w = {b[63], b} + {a[63], a}; of = w[64] ^ w[63]; end
                4'h1: begin r = b - a; w = {b[63], b} - {a[63], a}; of = w[64] ^ w[63]; end
                4'h2: r = b & a;
                4'h3: r = b ^ a;
`ifdef EXE_MUL_EN
                4'h4: r = b * a;
`endif
                default: e.err = 1'b1;
            endcase
            if (!e.err) begin
                e.valE = r;
                if (sc) m_cc = {r == 64'd0, r[63], of};
            end
        end else if (ic == 4'h2 || ic == 4'h7) begin
            if (fn > 4'h6) e.err = 1'b1;
            else begin
                case (fn)
                    4'h0: e.cnd = 1'b1;
                    4'h1: e.cnd = lt || zf;
                    4'h2: e.cnd = lt;
                    4'h3: e.cnd = zf;
                    4'h4: e.cnd = !zf;
                    4'h5: e.cnd = !lt;
                    default: e.cnd = !lt && !zf;
                endcase
                if (ic == 4'h2) e.valE = a;
            end
        end else begin
            case (ic)
                4'h3: e.valE = c;
                4'h4, 4'h5: e.valE = b + c;
                4'h8, 4'hA: e.valE = b - 64'd8;
                4'h9, 4'hB: e.valE = b + 64'd8;
                default: e.valE = '0;
            endcase
        end
        sb_q.push_back(e);
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c, input logic sc);
        bit done;
        done = 1'b0;
        @(negedge clk);
        icode_i = ic; ifun_i = fn; valA_i = a; valB_i = b; valC_i = c; set_cc_i = sc;
        in_valid_i = 1'b1;
        for (int n = 0; n < 300 && !done; n++) begin
            #1;
            if (in_ready_o) begin
                chk("cc_at_accept", 64'(cc_o), 64'(m_cc));
                model_exec(ic, fn, a, b, c, sc);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready_o stayed 0 expected 1");
            in_valid_i = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid_i = 1'b0;
        end
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 4))
            0: return 64'($urandom_range(0, 16));
            1: return {$urandom(), $urandom()};
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            default: return '1;
        endcase
    endfunction

    task automatic do_reset_check(input string tag);
        @(negedge clk);
        in_reset = 1'b1;
        in_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk({tag, "_out_valid"}, 64'(out_valid_o), 64'd0);
        chk({tag, "_cc"}, 64'(cc_o), 64'(3'b100));
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        sb_q.delete();
        m_cc = 3'b100;
        @(negedge clk);
        in_reset = 1'b0;
    endtask

    // Monitor: drives out_ready_i, pops and compares results, checks hold stability.
    initial begin
        exp_t        e;
        bit          hold;
        logic [63:0] h_valE, h_valA;
        logic [3:0]  h_icode;
        logic        h_cnd, h_err;
        hold = 1'b0;
        h_valE = '0; h_valA = '0; h_icode = '0; h_cnd = 1'b0; h_err = 1'b0;
        forever begin
            @(negedge clk);
            out_ready_i = (ready_mode == 0) ? 1'b1 :
                          (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (in_reset) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                chk("hold_valid", 64'(out_valid_o), 64'd1);
                chk("hold_valE", valE_o, h_valE);
                chk("hold_valA", valA_o, h_valA);
                chk("hold_icode", 64'(icode_o), 64'(h_icode));
                chk("hold_cnd_err", 64'({Cnd_o, instr_err_o}), 64'({h_cnd, h_err}));
            end
            if (out_valid_o && !out_ready_i)
                chk("in_ready_backpressure", 64'(in_ready_o), 64'd0);
            if (out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_output: valE 0x%0h with empty scoreboard", valE_o);
                end else begin
                    e = sb_q.pop_front();
                    chk("icode", 64'(icode_o), 64'(e.icode));
                    chk("valA", valA_o, e.valA);
                    chk("valE", valE_o, e.valE);
                    chk("Cnd", 64'(Cnd_o), 64'(e.cnd));
                    chk("instr_err", 64'(instr_err_o), 64'(e.err));
                end
            end
            hold = out_valid_o && !out_ready_i;
            h_valE = valE_o; h_valA = valA_o; h_icode = icode_o;
            h_cnd = Cnd_o; h_err = instr_err_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit drained;
        in_reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_valE", valE_o, 64'd0);
        chk("rst_valA", valA_o, 64'd0);
        chk("rst_icode", 64'(icode_o), 64'd0);
        chk("rst_Cnd", 64'(Cnd_o), 64'd0);
        chk("rst_err", 64'(instr_err_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_cc", 64'(cc_o), 64'(3'b100));
        @(negedge clk);
        rst_i = 1'b0;
        in_reset = 1'b0;
        ready_mode = 0;

        // Directed cases.
        send(4'h6, 4'h0, 64'd4, 64'd3, 64'd0, 1'b1);
        idle(2); #1;
        chk("cc_after_add", 64'(cc_o), 64'(3'b000));
        send(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b1);
        send(4'h2, 4'h1, 64'h2A, 64'd0, 64'd0, 1'b0);
        idle(2); #1;
        chk("cc_after_sub", 64'(cc_o), 64'(3'b100));
        send(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        send(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 1'b0);
        idle(2); #1;
        chk("cc_after_ovf", 64'(cc_o), 64'(3'b011));
        send(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 1'b0);
        send(4'h8, 4'h0, 64'd0, 64'h100, 64'd0, 1'b0);
        send(4'h9, 4'h0, 64'd0, 64'h100, 64'd0, 1'b0);
        send(4'h5, 4'h0, 64'd0, 64'h10, 64'h8, 1'b0);
        send(4'hC, 4'h0, 64'd1, 64'd2, 64'd3, 1'b1);
        send(4'h6, 4'h5, 64'd1, 64'd2, 64'd3, 1'b1);
        send(4'h7, 4'h7, 64'd1, 64'd2, 64'd3, 1'b0);
        idle(2);

        // Back-pressure: second instruction must wait until the slot drains.
        ready_mode = 2;
        fork
            begin
                send(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 1'b1);
                send(4'h6, 4'h2, 64'hF0, 64'h3C, 64'd0, 1'b1);
            end
            begin
                repeat (6) @(negedge clk);
                ready_mode = 0;
            end
        join
        idle(3);

        // Reset with a full slot and modified CC.
        ready_mode = 2;
        send(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 1'b1);
        idle(3);
        do_reset_check("rst_full");
        ready_mode = 0;

`ifdef EXE_MUL_EN
        send(4'h6, 4'h4, 64'd6, 64'd7, 64'd0, 1'b1);
        idle(2); #1;
        chk("mul_busy", 64'(busy_o), 64'd1);
        idle(70);
        send(4'h6, 4'h4, 64'd3, 64'd9, 64'd0, 1'b1);
        idle(10);
        do_reset_check("rst_mul");
`endif

        // Randomized traffic with random downstream stalls.
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            logic [3:0] ic, fn;
            ic = 4'($urandom_range(0, 13));
            fn = (ic == 4'h2 || ic == 4'h6 || ic == 4'h7) ? 4'($urandom_range(0, 7))
                                                          : 4'($urandom_range(0, 15));
            send(ic, fn, rnd64(), rnd64(), rnd64(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(1);
        ready_mode = 0;
        drained = 1'b0;
        for (int n = 0; n < 500 && !drained; n++) begin
            @(negedge clk);
            #2;
            if (sb_q.size() == 0) drained = 1'b1;
        end
        if (!drained) begin
            n_checks++; n_fail++;
            $display("FAIL drain: %0d results outstanding expected 0", sb_q.size());
        end
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
